eespfal_lane_sequencer: RTL and testbench

//  Digital phase sequencer for multi-lane EESPFAL adiabatic switch arrays.
//  Per lane: drives dual-rail x/k operands, the PHASES-step staircase clocks, and the Dis/Dis_Phase discharge.

---
 rtl/eespfal_lane_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_eespfal_lane_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/eespfal_lane_sequencer.sv
// Phase sequencer for multi-lane EESPFAL adiabatic switch arrays: dual-rail operand drive,
// staircase clocks, discharge and dual-rail capture. Optional macro EESPFAL_ERRCNT_EN adds err_count.
module eespfal_lane_sequencer #(
  parameter int LANES    = 4,
  parameter int BIT_SIZE = 64,
  parameter int PHASES   = 4,
  parameter int DIV_W    = 8
) (
`ifdef EESPFAL_ERRCNT_EN
  output logic [15:0]                 err_count,
`endif
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        start,
  // one code point beyond the lane count so an out-of-range select can be requested and rejected
  input  logic [$clog2(LANES):0]      lane_sel,
  input  logic [DIV_W-1:0]            phase_div,
  input  logic [BIT_SIZE-1:0]         x_in,
  input  logic [BIT_SIZE-1:0]         k_in,
  output logic                        busy,
  output logic                        done,
  output logic                        lane_err,
  output logic [BIT_SIZE-1:0]         s_out,
  output logic                        rail_err,
  output logic [LANES*BIT_SIZE-1:0]   x_top,
  output logic [LANES*BIT_SIZE-1:0]   x_bar_top,
  output logic [LANES*BIT_SIZE-1:0]   k_top,
  output logic [LANES*BIT_SIZE-1:0]   k_bar_top,
  output logic [LANES*PHASES-1:0]     clk_top,
  output logic [LANES*PHASES-1:0]     Dis_top,
  output logic                        Dis_Phase_top,
  input  logic [LANES*BIT_SIZE-1:0]   s_top,
  input  logic [LANES*BIT_SIZE-1:0]   s_bar_top
);

  localparam int SEL_W = $clog2(LANES) + 1;
  localparam int PH_W  = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam logic [SEL_W-1:0] LANES_V = SEL_W'(LANES);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(PHASES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RISE, S_EVAL, S_FALL, S_DISCH, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [DIV_W-1:0]          cnt_q, cnt_d, div_q, div_d;
  logic [PH_W-1:0]           ph_q, ph_d;
  logic [SEL_W-1:0]          lane_q, lane_d;
  logic [BIT_SIZE-1:0]       x_q, x_d, k_q, k_d;
  logic                      step_last, drive;

  logic                      busy_q, busy_d, done_q, done_d, lane_err_q, lane_err_d;
  logic                      rail_err_q, rail_err_d, dis_phase_q, dis_phase_d;
  logic [BIT_SIZE-1:0]       s_out_q, s_out_d;
  logic [LANES*BIT_SIZE-1:0] x_top_q, x_top_d, x_bar_q, x_bar_d;
  logic [LANES*BIT_SIZE-1:0] k_top_q, k_top_d, k_bar_q, k_bar_d;
  logic [LANES*PHASES-1:0]   clk_top_q, clk_top_d, dis_top_q, dis_top_d;

`ifdef EESPFAL_ERRCNT_EN
  logic [15:0] err_count_q, err_count_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ph_d       = ph_q;
    lane_d     = lane_q;
    div_d      = div_q;
    x_d        = x_q;
    k_d        = k_q;
    lane_err_d = 1'b0;
    step_last  = (cnt_q == div_q);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (lane_sel < LANES_V) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            lane_d  = lane_sel;
            div_d   = phase_div;
            x_d     = x_in;
            k_d     = k_in;
          end else begin
            lane_err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        cnt_d = cnt_q + 1'b1;
        if (step_last) begin
          state_d = S_RISE;
          cnt_d   = '0;
          ph_d    = '0;
        end
      end
      S_RISE: begin
        cnt_d = cnt_q + 1'b1;
        if (step_last) begin
          cnt_d = '0;
          if (ph_q == PH_LAST) state_d = S_EVAL;
          else                 ph_d    = ph_q + 1'b1;
        end
      end
      S_EVAL: begin
        state_d = S_FALL;
        cnt_d   = '0;
        ph_d    = PH_LAST;
      end
      S_FALL: begin
        cnt_d = cnt_q + 1'b1;
        if (step_last) begin
          cnt_d = '0;
          if (ph_q == '0) state_d = S_DISCH;
          else            ph_d    = ph_q - 1'b1;
        end
      end
      S_DISCH: begin
        cnt_d = cnt_q + 1'b1;
        if (step_last) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered in step with it
    drive     = (state_d == S_LOAD) || (state_d == S_RISE) ||
                (state_d == S_EVAL) || (state_d == S_FALL);
    x_top_d   = '0;
    x_bar_d   = '0;
    k_top_d   = '0;
    k_bar_d   = '0;
    clk_top_d = '0;
    dis_top_d = '0;
    for (int l = 0; l < LANES; l++) begin
      if (SEL_W'(l) == lane_d) begin
        if (drive) begin
          x_top_d[l*BIT_SIZE +: BIT_SIZE] = x_d;
          x_bar_d[l*BIT_SIZE +: BIT_SIZE] = ~x_d;
          k_top_d[l*BIT_SIZE +: BIT_SIZE] = k_d;
          k_bar_d[l*BIT_SIZE +: BIT_SIZE] = ~k_d;
        end
        for (int p = 0; p < PHASES; p++) begin
          clk_top_d[l*PHASES+p] = (state_d == S_EVAL) ||
                                  ((state_d == S_RISE) && (PH_W'(p) <= ph_d)) ||
                                  ((state_d == S_FALL) && (PH_W'(p) <  ph_d));
          dis_top_d[l*PHASES+p] = (state_d == S_DISCH);
        end
      end
    end
    dis_phase_d = (state_d == S_DISCH);
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);

    s_out_d    = s_out_q;
    rail_err_d = rail_err_q;
    if (state_q == S_EVAL) begin
      for (int l = 0; l < LANES; l++) begin
        if (SEL_W'(l) == lane_q) begin
          s_out_d    = s_top[l*BIT_SIZE +: BIT_SIZE];
          rail_err_d = |(~(s_top[l*BIT_SIZE +: BIT_SIZE] ^ s_bar_top[l*BIT_SIZE +: BIT_SIZE]));
        end
      end
    end
`ifdef EESPFAL_ERRCNT_EN
    err_count_d = err_count_q;
    if ((state_q == S_EVAL) && rail_err_d) err_count_d = sat_inc(err_count_q);
`endif
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ph_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lane_err_q  <= 1'b0;
      rail_err_q  <= 1'b0;
      dis_phase_q <= 1'b0;
      s_out_q     <= '0;
      x_top_q     <= '0;
      x_bar_q     <= '0;
      k_top_q     <= '0;
      k_bar_q     <= '0;
      clk_top_q   <= '0;
      dis_top_q   <= '0;
`ifdef EESPFAL_ERRCNT_EN
      err_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ph_q        <= ph_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      lane_err_q  <= lane_err_d;
      rail_err_q  <= rail_err_d;
      dis_phase_q <= dis_phase_d;
      s_out_q     <= s_out_d;
      x_top_q     <= x_top_d;
      x_bar_q     <= x_bar_d;
      k_top_q     <= k_top_d;
      k_bar_q     <= k_bar_d;
      clk_top_q   <= clk_top_d;
      dis_top_q   <= dis_top_d;
`ifdef EESPFAL_ERRCNT_EN
      err_count_q <= err_count_d;
`endif
    end
    lane_q <= lane_d;
    div_q  <= div_d;
    x_q    <= x_d;
    k_q    <= k_d;
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign lane_err      = lane_err_q;
  assign s_out         = s_out_q;
  assign rail_err      = rail_err_q;
  assign x_top         = x_top_q;
  assign x_bar_top     = x_bar_q;
  assign k_top         = k_top_q;
  assign k_bar_top     = k_bar_q;
  assign clk_top       = clk_top_q;
  assign Dis_top       = dis_top_q;
  assign Dis_Phase_top = dis_phase_q;
`ifdef EESPFAL_ERRCNT_EN
  assign err_count     = err_count_q;
`endif

endmodule

// File: tb/tb_eespfal_lane_sequencer.sv
// Randomized bench for eespfal_lane_sequencer: a timeline model (cycles since accept) predicts
// every output each cycle; directed segments cover reset, timing, rail errors and rejects.
module tb_eespfal_lane_sequencer;
  localparam int LANES = 4;
  localparam int BS    = 64;
  localparam int PH    = 4;
  localparam int DW    = 8;

  logic                 clk = 1'b0;
  logic                 rst, start;
  logic [2:0]           lane_sel;
  logic [DW-1:0]        phase_div;
  logic [BS-1:0]        x_in, k_in, s_out;
  logic                 busy, done, lane_err, rail_err, dis_phase;
  logic [LANES*BS-1:0]  x_top, x_bar_top, k_top, k_bar_top, s_top, s_bar_top;
  logic [LANES*PH-1:0]  clk_top, dis_top;
`ifdef EESPFAL_ERRCNT_EN
  logic [15:0]          err_count;
`endif

  always #5 clk = ~clk;

  eespfal_lane_sequencer #(.LANES(LANES), .BIT_SIZE(BS), .PHASES(PH), .DIV_W(DW)) dut (
`ifdef EESPFAL_ERRCNT_EN
    .err_count(err_count),
`endif
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .lane_sel(lane_sel),
    .phase_div(phase_div), .x_in(x_in), .k_in(k_in), .busy(busy), .done(done),
    .lane_err(lane_err), .s_out(s_out), .rail_err(rail_err), .x_top(x_top),
    .x_bar_top(x_bar_top), .k_top(k_top), .k_bar_top(k_bar_top), .clk_top(clk_top),
    .Dis_top(dis_top), .Dis_Phase_top(dis_phase), .s_top(s_top), .s_bar_top(s_bar_top)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Model: an operation is a timeline; m_t counts edges since the accepting edge
  bit          m_act = 0;
  int          m_t, m_n, m_l;
  logic [63:0] m_x, m_k, m_s = '0;
  logic        m_rerr = 1'b0, m_lerr;
  int          m_ecnt = 0;
  int          dones = 0;

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic step(input bit r, input bit st, input int sel, input int div,
                      input logic [63:0] xi, input logic [63:0] ki,
                      input logic [255:0] s, input logic [255:0] sb);
    logic [255:0] ex, exb, ek, ekb;
    logic [15:0]  eclk, edis;
    logic [3:0]   nib;
    logic [63:0]  ss, ssb;
    int           t, n, p;
    @(negedge clk);
    rst = r; start = st; lane_sel = sel[2:0]; phase_div = div[DW-1:0];
    x_in = xi; k_in = ki; s_top = s; s_bar_top = sb;
    @(posedge clk);
    m_lerr = 1'b0;
    if (r) begin
      m_act = 0; m_s = '0; m_rerr = 1'b0; m_ecnt = 0;
    end else if (m_act) begin
      if (m_t == 5*m_n) begin
        ss = s[m_l*64 +: 64]; ssb = sb[m_l*64 +: 64];
        m_s = ss;
        m_rerr = |(~(ss ^ ssb));
        if (m_rerr && m_ecnt < 65535) m_ecnt++;
      end
      m_t++;
      if (m_t > 10*m_n + 1) m_act = 0;
    end else if (st) begin
      if (sel < LANES) begin
        m_act = 1; m_t = 0; m_n = div + 1; m_l = sel; m_x = xi; m_k = ki;
      end else m_lerr = 1'b1;
    end
    #1;
    ex = '0; exb = '0; ek = '0; ekb = '0; eclk = '0; edis = '0; nib = '0;
    t = m_t; n = m_n;
    if (m_act) begin
      if (t <= 9*n) begin
        ex  = {192'b0, m_x}  << (m_l*64);
        exb = {192'b0, ~m_x} << (m_l*64);
        ek  = {192'b0, m_k}  << (m_l*64);
        ekb = {192'b0, ~m_k} << (m_l*64);
      end
      if (t >= n && t < 5*n) begin
        p = (t - n) / n;
        nib = 4'((1 << (p + 1)) - 1);
      end else if (t == 5*n) nib = 4'hF;
      else if (t >= 5*n + 1 && t <= 9*n) begin
        p = 3 - (t - 5*n - 1) / n;
        nib = 4'((1 << p) - 1);
      end
      eclk = {12'b0, nib} << (m_l*4);
      if (t >= 9*n + 1 && t <= 10*n) edis = 16'hF << (m_l*4);
    end
    if (done) dones++;
    check("x_top",     256'(x_top),     ex);
    check("x_bar_top", 256'(x_bar_top), exb);
    check("k_top",     256'(k_top),     ek);
    check("k_bar_top", 256'(k_bar_top), ekb);
    check("clk_top",   256'(clk_top),   256'(eclk));
    check("Dis_top",   256'(dis_top),   256'(edis));
    check("Dis_Phase", 256'(dis_phase), 256'(edis != 0));
    check("done",      256'(done),      256'(m_act && t == 10*n + 1));
    check("busy",      256'(busy),      256'(m_act));
    check("lane_err",  256'(lane_err),  256'(m_lerr));
    check("s_out",     256'(s_out),     256'(m_s));
    check("rail_err",  256'(rail_err),  256'(m_rerr));
`ifdef EESPFAL_ERRCNT_EN
    check("err_count", 256'(err_count), 256'(m_ecnt));
`endif
  endtask

  logic [255:0] rs, rsb;
  int           bpos, d0;

  initial begin
    rst = 1'b1; start = 1'b0; lane_sel = '0; phase_div = '0;
    x_in = '0; k_in = '0; s_top = '0; s_bar_top = '0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset while lane 2 is in RISE step 2
    step(0, 1, 2, 0, 64'hDEAD, 64'hBEEF, 0, '1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, '1);
    step(1, 0, 0, 0, 0, 0, 0, '1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, '1);

    // Lane 0, D=0, clean dual rails
    rs = 256'hA5; rsb = ~rs;
    d0 = dones;
    step(0, 1, 0, 0, 64'h1, 64'h0, rs, rsb);
    for (int i = 0; i < 13; i++) step(0, 0, 0, 0, 0, 0, rs, rsb);
    check("done_count_t2", 256'(dones - d0), 256'(1));

    // Lane 3, D=2, start pulses during busy ignored
    d0 = dones;
    step(0, 1, 3, 2, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, rnd256(), rnd256());
    for (int i = 0; i < 34; i++) step(0, (i % 5) == 0, i % 4, 0, 64'h5, 64'h6, rs, rsb);
    check("done_count_t3", 256'(dones - d0), 256'(1));

    // Lane 1 with s_bar equal to s: rail error
    rs = rnd256(); rsb = rs;
    step(0, 1, 1, 0, 64'h77, 64'h88, rs, rsb);
    for (int i = 0; i < 13; i++) step(0, 0, 0, 0, 0, 0, rs, rsb);

    // Out-of-range lane rejected
    step(0, 1, 4, 0, 0, 0, 0, 0);
    step(0, 1, 7, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // start held continuously: one done every 13 cycles
    d0 = dones;
    for (int i = 0; i < 52; i++) step(0, 1, 2, 0, 64'hF0F0, 64'h0F0F, rs, ~rs);
    check("done_count_t6", 256'(dones - d0), 256'(4));

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rs  = rnd256();
      rsb = ~rs;
      if ($urandom_range(0, 2) == 0) begin
        bpos = $urandom_range(0, 255);
        rsb[bpos] = rs[bpos];
      end
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 5 ? 4 + $urandom_range(0, 3) : $urandom_range(0, 3),
           $urandom_range(0, 3), {$urandom, $urandom}, {$urandom, $urandom}, rs, rsb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
